// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture block: segment bit masks, digit patterns, FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_A = 7'h01;
    localparam logic [6:0] SEG_B = 7'h02;
    localparam logic [6:0] SEG_C = 7'h04;
    localparam logic [6:0] SEG_D = 7'h08;
    localparam logic [6:0] SEG_E = 7'h10;
    localparam logic [6:0] SEG_F = 7'h20;
    localparam logic [6:0] SEG_G = 7'h40;

    localparam logic [6:0] SEG_DARK    = 7'h00;
    localparam logic [6:0] SEG_DIGIT_0 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
    localparam logic [6:0] SEG_DIGIT_1 = SEG_B | SEG_C;
    localparam logic [6:0] SEG_DIGIT_2 = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
    localparam logic [6:0] SEG_DIGIT_3 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
    localparam logic [6:0] SEG_DIGIT_4 = SEG_B | SEG_C | SEG_F | SEG_G;
    localparam logic [6:0] SEG_DIGIT_5 = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
    localparam logic [6:0] SEG_DIGIT_6 = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
    localparam logic [6:0] SEG_DIGIT_7 = SEG_A | SEG_B | SEG_C;
    localparam logic [6:0] SEG_DIGIT_8 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
    localparam logic [6:0] SEG_DIGIT_9 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Strict 7-segment pattern to BCD decoder; purely combinational, no backpressure.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic       o_valid,
    output logic [3:0] o_digit
);

    always_comb begin
        o_valid = 1'b1;
        o_digit = 4'd0;
        case (i_pat)
            SEG_DIGIT_0: o_digit = 4'd0;
            SEG_DIGIT_1: o_digit = 4'd1;
            SEG_DIGIT_2: o_digit = 4'd2;
            SEG_DIGIT_3: o_digit = 4'd3;
            SEG_DIGIT_4: o_digit = 4'd4;
            SEG_DIGIT_5: o_digit = 4'd5;
            SEG_DIGIT_6: o_digit = 4'd6;
            SEG_DIGIT_7: o_digit = 4'd7;
            SEG_DIGIT_8: o_digit = 4'd8;
            SEG_DIGIT_9: o_digit = 4'd9;
            default:     o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_mux_capture.sv
// Snoops a muxed two-digit 7-seg bus back to BCD; capture visible 2+STABLE_CYCLES after pins settle, no backpressure.
// Optional SEG7_CAPTURE_BIN_EN adds a registered binary readback on value_bin.
module seg7_mux_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic [1:0] com_in,
    input  logic       seg_pol,
    input  logic       com_pol,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       ones_blank,
    output logic       tens_blank,
    output logic       update,
    output logic       pat_err,
    output logic       collision,
    output logic [6:0] value_bin
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [6:0]    r_seg_s1, r_seg_s2, r_prev_seg;
    logic [1:0]    r_com_s1, r_com_s2, r_sync_vld;
    cap_state_t    r_state [2];
    logic [SW-1:0] r_cnt   [2];
    logic [TW-1:0] r_idle  [2];
    logic [3:0]    r_ones, r_tens;
    logic          r_ob, r_tb, r_update, r_pat_err, r_collision;

    logic [6:0]    w_seg;
    logic [1:0]    w_com, w_act, w_hit, w_cap, w_err, w_tmo, w_dec_vld;
    logic          w_coll;
    logic [3:0]    w_dec_dig [2];
    logic [SW-1:0] w_cnt_nxt [2];
    logic [3:0]    w_ones_nxt, w_tens_nxt;
    logic          w_ob_nxt, w_tb_nxt;

    // Commons are ignored until the synchronizer has flushed its reset contents.
    assign w_seg  = r_seg_s2 ^ {7{~seg_pol}};
    assign w_com  = r_sync_vld[1] ? (r_com_s2 ^ {2{~com_pol}}) : 2'b00;
    assign w_coll = &w_com;
    assign w_act  = w_com & {2{~w_coll}};

    for (genvar d = 0; d < 2; d++) begin : g_dec
        seg7_pattern_decode u_dec (
            .i_pat   (w_seg),
            .o_valid (w_dec_vld[d]),
            .o_digit (w_dec_dig[d])
        );
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            w_cnt_nxt[d] = (r_state[d] == ST_SETTLE && w_seg == r_prev_seg) ?
                           r_cnt[d] + 1'b1 : SW'(1);
            w_hit[d] = w_act[d] && (r_state[d] != ST_DONE) &&
                       (w_cnt_nxt[d] == SW'(STABLE_CYCLES));
            w_cap[d] = w_hit[d] & w_dec_vld[d];
            w_err[d] = w_hit[d] & ~w_dec_vld[d] & (w_seg != SEG_DARK);
            w_tmo[d] = (r_idle[d] == TW'(TIMEOUT_CYCLES));
        end
    end

    assign w_ones_nxt = w_cap[0] ? w_dec_dig[0] : r_ones;
    assign w_ob_nxt   = w_cap[0] ? 1'b0 : (r_ob | w_tmo[0]);
    assign w_tens_nxt = w_cap[1] ? w_dec_dig[1] : (w_tmo[1] ? 4'd0 : r_tens);
    assign w_tb_nxt   = w_cap[1] ? 1'b0 : (r_tb | w_tmo[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_s1    <= '0;
            r_seg_s2    <= '0;
            r_prev_seg  <= '0;
            r_com_s1    <= '0;
            r_com_s2    <= '0;
            r_sync_vld  <= '0;
            r_ones      <= '0;
            r_tens      <= '0;
            r_ob        <= 1'b1;
            r_tb        <= 1'b1;
            r_update    <= 1'b0;
            r_pat_err   <= 1'b0;
            r_collision <= 1'b0;
            for (int d = 0; d < 2; d++) begin
                r_state[d] <= ST_IDLE;
                r_cnt[d]   <= '0;
                r_idle[d]  <= '0;
            end
        end else begin
            r_seg_s1    <= seg_in;
            r_seg_s2    <= r_seg_s1;
            r_com_s1    <= com_in;
            r_com_s2    <= r_com_s1;
            r_sync_vld  <= {r_sync_vld[0], 1'b1};
            r_prev_seg  <= w_seg;
            r_ones      <= w_ones_nxt;
            r_tens      <= w_tens_nxt;
            r_ob        <= w_ob_nxt;
            r_tb        <= w_tb_nxt;
            r_update    <= {w_ones_nxt, w_tens_nxt, w_ob_nxt, w_tb_nxt} !=
                           {r_ones, r_tens, r_ob, r_tb};
            r_pat_err   <= |w_err;
            r_collision <= w_coll;
            for (int d = 0; d < 2; d++) begin
                if (w_cap[d]) begin
                    r_idle[d] <= '0;
                end else if (!w_coll && !w_com[d] && !w_tmo[d]) begin
                    r_idle[d] <= r_idle[d] + 1'b1;
                end
                // DONE latches until the common drops: one capture per window.
                case (r_state[d])
                    ST_IDLE: begin
                        if (w_act[d]) begin
                            r_state[d] <= ST_SETTLE;
                            r_cnt[d]   <= w_cnt_nxt[d];
                        end
                    end
                    ST_SETTLE: begin
                        if (!w_act[d]) begin
                            r_state[d] <= ST_IDLE;
                        end else if (w_hit[d]) begin
                            r_state[d] <= ST_DONE;
                        end else begin
                            r_cnt[d] <= w_cnt_nxt[d];
                        end
                    end
                    ST_DONE: begin
                        if (!w_act[d]) begin
                            r_state[d] <= ST_IDLE;
                        end
                    end
                    default: r_state[d] <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SEG7_CAPTURE_BIN_EN
    logic [6:0] r_value_bin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value_bin <= '0;
        end else begin
            r_value_bin <= w_ob_nxt ? 7'd0 :
                           ({3'd0, w_tens_nxt} * 7'd10 + {3'd0, w_ones_nxt});
        end
    end

    assign value_bin = r_value_bin;
`else
    assign value_bin = 7'd0;
`endif

    assign ones       = r_ones;
    assign tens       = r_tens;
    assign ones_blank = r_ob;
    assign tens_blank = r_tb;
    assign update     = r_update;
    assign pat_err    = r_pat_err;
    assign collision  = r_collision;

endmodule

// File: tb/tb_seg7_mux_capture.sv
// Directed bench for seg7_mux_capture: latency, polarity, stability filter, timeout blanking, pat_err, collision.
module tb_seg7_mux_capture;

    localparam int TMO = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic [1:0] com_in;
    logic       seg_pol, com_pol;
    logic [3:0] ones, tens;
    logic       ones_blank, tens_blank, update, pat_err, collision;
    logic [6:0] value_bin;

    int checks   = 0;
    int failures = 0;
    int n_upd = 0, n_err = 0, n_col = 0;
    int snap_upd, snap_err, snap_col;
    int exp27, exp3;

    seg7_mux_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .com_in     (com_in),
        .seg_pol    (seg_pol),
        .com_pol    (com_pol),
        .ones       (ones),
        .tens       (tens),
        .ones_blank (ones_blank),
        .tens_blank (tens_blank),
        .update     (update),
        .pat_err    (pat_err),
        .collision  (collision),
        .value_bin  (value_bin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (update)    n_upd <= n_upd + 1;
        if (pat_err)   n_err <= n_err + 1;
        if (collision) n_col <= n_col + 1;
    end

    task automatic drive(input logic [1:0] com, input logic [6:0] seg);
        com_in = com_pol ? com : ~com;
        seg_in = seg_pol ? seg : ~seg;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic rounds(input int n);
        repeat (n) begin
            drive(2'b01, 7'h07);
            cyc(8);
            drive(2'b10, 7'h5B);
            cyc(8);
        end
    endtask

    initial begin
`ifdef SEG7_CAPTURE_BIN_EN
        exp27 = 27;
        exp3  = 3;
`else
        exp27 = 0;
        exp3  = 0;
`endif
        seg_pol = 1'b1;
        com_pol = 1'b1;
        rst     = 1'b1;
        drive(2'b00, 7'h00);
        cyc(3);
        chk("rst_ones", ones, 0);
        chk("rst_tens", tens, 0);
        chk("rst_ones_blank", ones_blank, 1);
        chk("rst_tens_blank", tens_blank, 1);
        chk("rst_update", update, 0);
        chk("rst_pat_err", pat_err, 0);
        chk("rst_collision", collision, 0);
        chk("rst_value_bin", value_bin, 0);

        // First ones capture: pins set here, visible after the 6th rising edge.
        snap_upd = n_upd;
        rst = 1'b0;
        drive(2'b01, 7'h07);
        cyc(5);
        chk("lat_before", ones, 0);
        cyc(1);
        chk("lat_ones", ones, 7);
        chk("lat_update", update, 1);
        chk("lat_ones_blank", ones_blank, 0);
        cyc(2);
        drive(2'b10, 7'h5B);
        cyc(8);
        rounds(2);
        chk("pos_ones", ones, 7);
        chk("pos_tens", tens, 2);
        chk("pos_tens_blank", tens_blank, 0);
        chk("pos_value_bin", value_bin, exp27);
        drive(2'b00, 7'h00);
        cyc(3);
        chk("pos_update_count", n_upd - snap_upd, 2);

        // Reset in the middle of a window.
        drive(2'b01, 7'h07);
        cyc(3);
        rst = 1'b1;
        #1;
        chk("midrst_ones", ones, 0);
        chk("midrst_tens", tens, 0);
        chk("midrst_tens_blank", tens_blank, 1);
        chk("midrst_value_bin", value_bin, 0);
        snap_upd = n_upd;
        cyc(3);
        chk("midrst_no_update", n_upd - snap_upd, 0);

        // Inverted polarity on both buses.
        seg_pol = 1'b0;
        com_pol = 1'b0;
        drive(2'b00, 7'h00);
        cyc(1);
        snap_upd = n_upd;
        snap_err = n_err;
        snap_col = n_col;
        rst = 1'b0;
        rounds(3);
        chk("neg_ones", ones, 7);
        chk("neg_tens", tens, 2);
        chk("neg_tens_blank", tens_blank, 0);
        chk("neg_value_bin", value_bin, exp27);
        drive(2'b00, 7'h00);
        cyc(3);
        chk("neg_update_count", n_upd - snap_upd, 2);
        chk("neg_pat_err_count", n_err - snap_err, 0);
        chk("neg_collision_count", n_col - snap_col, 0);

        // Pattern toggling every 2 cycles never becomes stable.
        snap_upd = n_upd;
        snap_err = n_err;
        for (int i = 0; i < 8; i++) begin
            drive(2'b01, (i % 2 == 0) ? 7'h06 : 7'h4F);
            cyc(2);
        end
        drive(2'b00, 7'h00);
        cyc(4);
        chk("tog_ones", ones, 7);
        chk("tog_update_count", n_upd - snap_upd, 0);
        chk("tog_pat_err_count", n_err - snap_err, 0);

        // Tens timeout while only the ones common is driven.
        drive(2'b10, 7'h5B);
        cyc(8);
        snap_upd = n_upd;
        drive(2'b01, 7'h4F);
        cyc(6);
        chk("tmo_ones_new", ones, 3);
        cyc(TMO - 4);
        chk("tmo_blank_before", tens_blank, 0);
        cyc(1);
        chk("tmo_blank_set", tens_blank, 1);
        chk("tmo_tens_zero", tens, 0);
        chk("tmo_update", update, 1);
        cyc(7);
        chk("tmo_ones_kept", ones, 3);
        chk("tmo_ones_blank", ones_blank, 0);
        chk("tmo_value_bin", value_bin, exp3);

        // Non-digit pattern on a fresh ones window.
        drive(2'b00, 7'h00);
        cyc(3);
        snap_err = n_err;
        drive(2'b01, 7'h49);
        cyc(6);
        chk("perr_pulse", pat_err, 1);
        chk("perr_ones_hold", ones, 3);
        cyc(1);
        chk("perr_pulse_end", pat_err, 0);
        drive(2'b00, 7'h00);
        cyc(3);
        chk("perr_count", n_err - snap_err, 1);
        chk("tmo_update_count", n_upd - snap_upd, 2);

        // Both commons active for 3 cycles.
        snap_upd = n_upd;
        snap_col = n_col;
        drive(2'b11, 7'h06);
        cyc(3);
        chk("coll_pulse", collision, 1);
        drive(2'b00, 7'h00);
        cyc(5);
        chk("coll_count", n_col - snap_col, 3);
        chk("coll_ones", ones, 3);
        chk("coll_tens", tens, 0);
        chk("coll_tens_blank", tens_blank, 1);
        chk("coll_no_update", n_upd - snap_upd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_mux_capture.md
# seg7_mux_capture

Receive-side counterpart of the dice display driver. Samples a multiplexed two-digit 7-segment bus (7 segment lines, 2 common lines), qualifies each digit window for stability and decodes the segment patterns back to BCD tens/ones. Supplies a registered, blank-aware readback of the displayed value. Runs on a capture clock at least 8x faster than the display mux rate. Used for on-board self-check and external display snooping.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples inside one active common window required to capture (≥2)
- TIMEOUT_CYCLES, 1024, cycles without an active window before that digit is declared blank
- clk  in  1  capture clock
- rst  in  1  reset, asynchronous, active-high
- seg_in  in  7  segment lines, bit0=a … bit6=g, asynchronous
- com_in  in  2  commons: [0]=ones digit, [1]=tens digit, asynchronous
- seg_pol  in  1  static; 1 = segments active-high
- com_pol  in  1  static; 1 = commons active-high
- ones  out  4  captured ones digit, BCD
- tens  out  4  captured tens digit, BCD
- ones_blank  out  1  ones digit not driven within TIMEOUT_CYCLES
- tens_blank  out  1  tens digit not driven within TIMEOUT_CYCLES (leading-zero blanking)
- update  out  1  one-cycle pulse when ones, tens or a blank flag changes
- pat_err  out  1  one-cycle pulse: stable pattern is not a digit
- collision  out  1  one-cycle pulse: both commons active in the same sample
- value_bin  out  7  binary value tens*10+ones (see Configuration)

## Operation
- seg_in/com_in pass through 2-flop synchronizers, then polarity correction (XOR with ~seg_pol / ~com_pol) so internal signals are active-high.
- Per digit, a 3-state FSM: IDLE (common inactive) -> SETTLE (common active; stable_cnt counts matching samples, reload to 1 when the pattern differs from the previous sample) -> DONE at stable_cnt == STABLE_CYCLES (decode once); any state -> IDLE when common goes inactive. DONE holds until the common drops, so exactly one capture per window.
- Decode (strict): 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9. 0x00 = dark: no capture, no error. Any other pattern: pat_err pulse, digit register holds.
- Valid capture: digit register loads, its blank flag clears, idle counter clears.
- Idle counter per digit increments in IDLE, saturates at TIMEOUT_CYCLES; on reaching it blank flag sets, tens forced to 0 when tens_blank sets (ones keeps value).
- Collision: both commons active in a sample -> collision pulse, both FSMs to IDLE, no capture that cycle; idle counters do not advance.
- update asserts in the cycle the changed outputs first become visible; no pulse on identical re-capture.

## Timing
- Reset values: ones=0, tens=0, ones_blank=1, tens_blank=1, update=0, pat_err=0, collision=0, value_bin=0; all FSMs IDLE, counters 0.
- Inputs stable at pins from cycle t -> captured digit and update visible in cycle t+2+STABLE_CYCLES.
- pat_err same cycle a valid capture would have been visible; collision 3 cycles after the colliding pins (sync + register).
- Blank flag sets TIMEOUT_CYCLES+3 cycles after common went inactive at pins.
- Reset mid-window: outputs return to reset values immediately (async); capture restarts fresh after release.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- SEG7_CAPTURE_BIN_EN defined: value_bin = tens*10+ones registered, updating in the same cycle as update; 0 while ones_blank.
- Not defined: value_bin tied to 0, multiplier/adder logic absent; port remains.

## Structure
- Package seg7_pkg: segment bit-order constants, the ten digit pattern constants, SEG_DARK, FSM state typedef.
- Sub-module seg7_pattern_decode: combinational 7-bit pattern -> {valid, digit[3:0]}, instantiated once per digit.
- Counter widths derived with $clog2 from the parameters.

## Test plan
- Reset asserted mid-run -> all outputs reset values, update never pulses during reset.
- Alternate com[0] 8 cycles with 0x07 and com[1] 8 cycles with 0x5B, pols=1 -> ones=7, tens=2, tens_blank=0, update pulses once per change, value_bin=27 with macro.
- Same traffic, seg_pol=0, com_pol=0, inverted pins -> identical result.
- com[0] window, pattern toggles every 2 cycles, STABLE_CYCLES=4 -> no capture, no update, no pat_err.
- Only com[0] active for TIMEOUT_CYCLES+10 -> tens_blank=1, tens=0, ones unaffected; 0x49 on ones window -> pat_err pulse, ones holds.
- Both commons active 3 cycles -> collision pulses, no digit change.
